md5_pad_seq: RTL and testbench

- Message-level sequencer in front of the MD5 block controller.
- Accepts an arbitrary-length byte message as a stream of 32-bit words.
- Applies MD5 padding: 0x80 marker, zero fill, and the 64-bit little-endian bit length.
- Buffers each 512-bit block and feeds it to the core as 16 back-to-back words; pulses the core reset at message start; captures the final 128-bit hash.

---
 rtl/md5_pad_seq.sv | 201 ++++++++++++++++++++
 tb/tb_md5_pad_seq.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/md5_pad_seq.sv
// Message-level MD5 sequencer: buffers the input stream into 512-bit blocks,
// applies MD5 padding and length, streams blocks to the core, returns the digest.
module md5_pad_seq #(
  parameter int LEN_W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic [2:0]   in_nbytes,
  input  logic         in_last,
  output logic         core_rst,
  output logic         core_rdy,
  output logic [31:0]  core_msg,
  input  logic         core_done,
  input  logic [127:0] core_hash,
  output logic [127:0] hash_o,
  output logic         done_o,
  output logic         busy_o
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    FILL,
    PAD,
    SEND,
    WAIT,
    FINISH
  } state_t;

  state_t           state;
  logic [31:0]      blk_buf [16];
  logic [3:0]       widx;
  logic [4:0]       sidx;
  logic [LEN_W-1:0] bcnt;
  logic             pend_pad;
  logic             no_len;
  logic             final_blk;

  logic [2:0]       nb;
  logic             is_last;
  logic [31:0]      marked;
  logic [63:0]      bit_len;
  logic [31:0]      pad_word;

  // Clamp the byte count; a short word always terminates the message.
  always_comb begin
    nb      = (in_nbytes > 3'd4) ? 3'd4 : in_nbytes;
    is_last = in_last || (nb != 3'd4);
    case (nb)
      3'd0:    marked = 32'h8000_0000;
      3'd1:    marked = {in_data[31:24], 24'h80_0000};
      3'd2:    marked = {in_data[31:16], 16'h8000};
      3'd3:    marked = {in_data[31:8], 8'h80};
      default: marked = in_data;
    endcase
  end

  assign bit_len = 64'(bcnt) << 3;

  // Length words go out little-endian in the last two slots of the final block.
  always_comb begin
    if (pend_pad) begin
      pad_word = 32'h8000_0000;
    end else if (no_len || (widx < 4'd14)) begin
      pad_word = '0;
    end else if (widx == 4'd14) begin
      pad_word = {bit_len[7:0], bit_len[15:8], bit_len[23:16], bit_len[31:24]};
    end else begin
      pad_word = {bit_len[39:32], bit_len[47:40], bit_len[55:48], bit_len[63:56]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      core_rst  <= 1'b0;
      core_rdy  <= 1'b0;
      core_msg  <= '0;
      hash_o    <= '0;
      done_o    <= 1'b0;
      busy_o    <= 1'b0;
      widx      <= '0;
      sidx      <= '0;
      bcnt      <= '0;
      pend_pad  <= 1'b0;
      no_len    <= 1'b0;
      final_blk <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        blk_buf[i] <= '0;
      end
    end else begin
      core_rst <= 1'b0;
      done_o   <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            state     <= START;
            core_rst  <= 1'b1;
            busy_o    <= 1'b1;
            widx      <= '0;
            bcnt      <= '0;
            pend_pad  <= 1'b0;
            no_len    <= 1'b0;
            final_blk <= 1'b0;
          end
        end

        START: begin
          state    <= FILL;
          in_ready <= 1'b1;
        end

        FILL: begin
          if (in_valid) begin
            blk_buf[widx] <= marked;
            bcnt          <= bcnt + LEN_W'(nb);
            widx          <= widx + 4'd1;
            if (is_last && (nb == 3'd4)) begin
              pend_pad <= 1'b1;
            end
            // Marker in slot 14/15 leaves no room for the length here.
            if (is_last && (nb != 3'd4) && (widx >= 4'd14)) begin
              no_len <= 1'b1;
            end
            if (widx == 4'd15) begin
              state    <= SEND;
              in_ready <= 1'b0;
              core_rdy <= 1'b1;
              core_msg <= blk_buf[0];
              sidx     <= 5'd1;
            end else if (is_last) begin
              state    <= PAD;
              in_ready <= 1'b0;
            end
          end
        end

        PAD: begin
          blk_buf[widx] <= pad_word;
          widx          <= widx + 4'd1;
          if (pend_pad) begin
            pend_pad <= 1'b0;
            if (widx >= 4'd14) begin
              no_len <= 1'b1;
            end
          end else if (!no_len && (widx == 4'd15)) begin
            final_blk <= 1'b1;
          end
          if (widx == 4'd15) begin
            state    <= SEND;
            core_rdy <= 1'b1;
            core_msg <= blk_buf[0];
            sidx     <= 5'd1;
          end
        end

        SEND: begin
          if (sidx == 5'd16) begin
            state    <= WAIT;
            core_rdy <= 1'b0;
            core_msg <= '0;
          end else begin
            core_msg <= blk_buf[sidx[3:0]];
            sidx     <= sidx + 5'd1;
          end
        end

        WAIT: begin
          if (core_done) begin
            widx   <= '0;
            no_len <= 1'b0;
            if (final_blk) begin
              state  <= FINISH;
              hash_o <= core_hash;
              done_o <= 1'b1;
              busy_o <= 1'b0;
            end else if (pend_pad || no_len) begin
              state <= PAD;
            end else begin
              state    <= FILL;
              in_ready <= 1'b1;
            end
          end
        end

        FINISH: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md5_pad_seq.sv
// Bench for md5_pad_seq: a reference MD5 core drives core_done/core_hash, and a
// byte-level padding model predicts every core word and the final digest.
`timescale 1ns/1ps
module tb_md5_pad_seq;

  typedef logic [7:0]  byte_q_t[$];
  typedef logic [31:0] word_q_t[$];

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  in_data = '0;
  logic [2:0]   in_nbytes = '0;
  logic         in_last = 1'b0;
  logic         core_rst;
  logic         core_rdy;
  logic [31:0]  core_msg;
  logic         core_done = 1'b0;
  logic [127:0] core_hash = '0;
  logic [127:0] hash_o;
  logic         done_o;
  logic         busy_o;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  md5_pad_seq #(.LEN_W(64)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_nbytes(in_nbytes), .in_last(in_last),
    .core_rst(core_rst), .core_rdy(core_rdy), .core_msg(core_msg),
    .core_done(core_done), .core_hash(core_hash),
    .hash_o(hash_o), .done_o(done_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check128(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- MD5 reference ----------------
  localparam logic [127:0] IV = {32'h67452301, 32'hefcdab89, 32'h98badcfe, 32'h10325476};
  localparam int RS [16] = '{7, 12, 17, 22, 5, 9, 14, 20, 4, 11, 16, 23, 6, 10, 15, 21};
  localparam logic [31:0] K [64] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };

  function automatic logic [31:0] bswap(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  // Block words arrive big-endian (first byte in [31:24]); MD5 reads them little-endian.
  function automatic logic [127:0] md5_block(input logic [127:0] st, input logic [31:0] w [16]);
    logic [31:0] a, b, c, d, f, t;
    int g, s;
    a = st[127:96]; b = st[95:64]; c = st[63:32]; d = st[31:0];
    for (int i = 0; i < 64; i++) begin
      if (i < 16)      begin f = (b & c) | (~b & d); g = i; end
      else if (i < 32) begin f = (d & b) | (~d & c); g = (5 * i + 1) % 16; end
      else if (i < 48) begin f = b ^ c ^ d;          g = (3 * i + 5) % 16; end
      else             begin f = c ^ (b | ~d);       g = (7 * i) % 16; end
      s = RS[(i / 16) * 4 + (i % 4)];
      t = f + a + K[i] + bswap(w[g]);
      a = d; d = c; c = b;
      b = b + ((t << s) | (t >> (32 - s)));
    end
    return {st[127:96] + a, st[95:64] + b, st[63:32] + c, st[31:0] + d};
  endfunction

  function automatic logic [127:0] digest(input logic [127:0] st);
    return {bswap(st[127:96]), bswap(st[95:64]), bswap(st[63:32]), bswap(st[31:0])};
  endfunction

  function automatic word_q_t pad_msg(input byte_q_t msg);
    byte_q_t p;
    word_q_t w;
    logic [63:0] bits;
    p = msg;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    bits = 64'(msg.size()) * 64'd8;
    for (int i = 0; i < 8; i++) p.push_back(bits[8*i +: 8]);
    for (int i = 0; i < p.size(); i += 4) w.push_back({p[i], p[i+1], p[i+2], p[i+3]});
    return w;
  endfunction

  function automatic logic [127:0] model_hash(input word_q_t w);
    logic [127:0] st;
    logic [31:0] blk [16];
    st = IV;
    for (int b = 0; b < w.size() / 16; b++) begin
      for (int j = 0; j < 16; j++) blk[j] = w[16*b + j];
      st = md5_block(st, blk);
    end
    return digest(st);
  endfunction

  function automatic byte_q_t pattern(input int n);
    byte_q_t m;
    for (int i = 0; i < n; i++) m.push_back(8'((i * 7 + 3) & 255));
    return m;
  endfunction

  // ---------------- core model ----------------
  logic [127:0] core_st;
  logic [31:0]  core_blk [16];
  int           core_n = 0;
  int           core_done_cyc = -100;

  initial begin
    core_st = IV;
    forever begin
      @(negedge clk);
      if (!rst) begin
        core_n = 0;
      end else if (core_rst) begin
        core_st = IV;
        core_n = 0;
      end else if (core_rdy) begin
        core_blk[core_n] = core_msg;
        core_n++;
        if (core_n == 16) begin
          core_n = 0;
          core_st = md5_block(core_st, core_blk);
          repeat (3) @(negedge clk);
          if (rst) begin
            core_hash = digest(core_st);
            core_done = 1'b1;
            core_done_cyc = cyc;
            @(negedge clk);
            core_done = 1'b0;
            core_hash = '0;
          end
        end
      end
    end
  end

  // ---------------- compare process ----------------
  word_q_t      exp_q;
  logic [127:0] exp_hash_q[$];
  word_q_t      sent_q;
  int           run = 0;
  int           rst_pulses = 0;
  int           done_cnt = 0;
  logic [127:0] last_hash = '0;

  always @(negedge clk) begin
    if (rst) begin
      if (core_rdy) begin
        sent_q.push_back(core_msg);
        if (exp_q.size() > 0) begin
          check32("core_msg", core_msg, exp_q.pop_front());
        end else begin
          n_cmp++; n_bad++;
          $display("FAIL core_msg_extra: got %h, expected no word", core_msg);
        end
        check32("in_ready_during_send", 32'(in_ready), 32'd0);
        run++;
      end else if (run > 0) begin
        check32("send_burst_len", run, 32'd16);
        run = 0;
      end
      if (core_rst) rst_pulses++;
      if (done_o) begin
        done_cnt++;
        last_hash = hash_o;
        if (exp_hash_q.size() > 0) begin
          check128("hash_o", hash_o, exp_hash_q.pop_front());
        end else begin
          n_cmp++; n_bad++;
          $display("FAIL done_extra: got done_o with hash %h, expected none", hash_o);
        end
        check32("done_latency", cyc - core_done_cyc, 32'd1);
        check32("busy_at_done", 32'(busy_o), 32'd0);
      end
    end else begin
      run = 0;
    end
  end

  // ---------------- driver ----------------
  task automatic feed_msg(input byte_q_t msg, input int nb_full, output logic [127:0] eh, output bit ok);
    word_q_t w;
    int nwords, nb, t;
    logic [31:0] data;
    w = pad_msg(msg);
    eh = model_hash(w);
    foreach (w[i]) exp_q.push_back(w[i]);
    exp_hash_q.push_back(eh);
    sent_q.delete();
    ok = 1'b1;
    nwords = (msg.size() == 0) ? 1 : (msg.size() + 3) / 4;
    for (int i = 0; i < nwords; i++) begin
      data = '0;
      nb = 0;
      for (int j = 0; j < 4; j++) begin
        if (4 * i + j < msg.size()) begin
          data[31 - 8*j -: 8] = msg[4*i + j];
          nb++;
        end
      end
      @(negedge clk);
      in_valid  = 1'b1;
      in_data   = data;
      in_nbytes = (nb == 4) ? 3'(nb_full) : 3'(nb);
      in_last   = (i == nwords - 1);
      t = 0;
      while (!in_ready && t < 300) begin
        @(negedge clk);
        t++;
      end
      if (t >= 300) begin
        n_cmp++; n_bad++;
        $display("FAIL in_ready_timeout: got no in_ready for word %0d, expected acceptance", i);
        in_valid = 1'b0;
        exp_q.delete();
        exp_hash_q.delete();
        ok = 1'b0;
        return;
      end
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic run_msg(input string name, input byte_q_t msg, input int nb_full);
    logic [127:0] eh;
    bit ok;
    int d0, r0, t;
    d0 = done_cnt;
    r0 = rst_pulses;
    feed_msg(msg, nb_full, eh, ok);
    if (!ok) return;
    t = 0;
    while (done_cnt == d0 && t < 600) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    check32({name, "_done_count"}, done_cnt - d0, 32'd1);
    check32({name, "_core_rst_count"}, rst_pulses - r0, 32'd1);
    check32({name, "_words_left"}, exp_q.size(), 32'd0);
    check128({name, "_hash_hold"}, hash_o, eh);
    $display("msg %s len=%0d words_sent=%0d hash=%h", name, msg.size(), sent_q.size(), hash_o);
  endtask

  initial begin
    byte_q_t m;
    logic [127:0] eh;
    bit ok;
    int t, d0;

    repeat (3) @(negedge clk);
    check32("rst_in_ready", 32'(in_ready), 32'd0);
    check32("rst_core_rst", 32'(core_rst), 32'd0);
    check32("rst_core_rdy", 32'(core_rdy), 32'd0);
    check32("rst_core_msg", core_msg, 32'd0);
    check32("rst_done", 32'(done_o), 32'd0);
    check32("rst_busy", 32'(busy_o), 32'd0);
    check128("rst_hash", hash_o, 128'd0);
    rst = 1'b1;

    m = {};
    run_msg("empty", m, 4);
    check32("empty_w0", sent_q[0], 32'h8000_0000);
    check32("empty_w15", sent_q[15], 32'h0);
    check128("empty_digest", last_hash, 128'hd41d8cd98f00b204e9800998ecf8427e);

    m = {8'h61, 8'h61, 8'h61, 8'h61};
    run_msg("aaaa", m, 4);
    check32("aaaa_w0", sent_q[0], 32'h6161_6161);
    check32("aaaa_w1", sent_q[1], 32'h8000_0000);
    check32("aaaa_w14", sent_q[14], 32'h2000_0000);
    check128("aaaa_digest", last_hash, 128'h74b87337454200d4d33f80c4663dc5e5);

    m = {8'h61, 8'h62, 8'h63};
    run_msg("abc", m, 4);
    check32("abc_w0", sent_q[0], 32'h6162_6380);
    check32("abc_w14", sent_q[14], 32'h1800_0000);
    check128("abc_digest", last_hash, 128'h900150983cd24fb0d6963f7d28e17f72);

    m = pattern(56);
    run_msg("len56", m, 4);
    check32("len56_words", sent_q.size(), 32'd32);
    check32("len56_b1w14", sent_q[14], 32'h8000_0000);
    check32("len56_b1w15", sent_q[15], 32'h0);
    check32("len56_b2w14", sent_q[30], 32'hC001_0000);

    m = pattern(5);  run_msg("len5", m, 4);
    m = pattern(55); run_msg("len55", m, 4);
    m = pattern(60); run_msg("len60", m, 4);
    m = pattern(63); run_msg("len63", m, 4);
    m = pattern(64); run_msg("len64", m, 4);
    m = pattern(80); run_msg("len80_stall", m, 4);
    m = pattern(8);  run_msg("nbytes7", m, 7);

    // Abort in the middle of a SEND burst.
    m = pattern(40);
    d0 = done_cnt;
    feed_msg(m, 4, eh, ok);
    t = 0;
    while (!core_rdy && t < 100) begin
      @(negedge clk);
      t++;
    end
    check32("abort_reached_send", 32'(core_rdy), 32'd1);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check32("abort_in_ready", 32'(in_ready), 32'd0);
    check32("abort_core_rst", 32'(core_rst), 32'd0);
    check32("abort_core_rdy", 32'(core_rdy), 32'd0);
    check32("abort_core_msg", core_msg, 32'd0);
    check32("abort_busy", 32'(busy_o), 32'd0);
    check128("abort_hash", hash_o, 128'd0);
    rst = 1'b1;
    exp_q.delete();
    exp_hash_q.delete();
    repeat (40) @(negedge clk);
    check32("abort_no_done", done_cnt - d0, 32'd0);

    m = {8'h61, 8'h61, 8'h61, 8'h61};
    run_msg("aaaa_after_abort", m, 4);
    check128("aaaa2_digest", last_hash, 128'h74b87337454200d4d33f80c4663dc5e5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    n_cmp++; n_bad++;
    $display("FAIL watchdog: simulation still running, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule
